// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared definitions for the RAM sequencer slice.
//   ADDR_W_DEF / DATA_W_DEF : default RAM geometry (32 x 8)
//   DEPTH                   : number of RAM words at the default geometry
//   seq_state_t             : sequencer FSM state encoding
package ram_seq_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCAN_WAIT,
        SCAN_READ,
        SCAN_CAPT
    } seq_state_t;

endpackage

// File: rtl/ram_sequencer_tick_divider.sv
// tick_divider: free-running divider that paces the read-back sweep.
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   run    : count while high; counter is held at zero while low
//   tick   : one-cycle pulse in the cycle the counter sits at TICK_DIV-1
module tick_divider #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/ram_sequencer.sv
// ram_sequencer: fills a single-port registered-read RAM from switches on
// each load_key rising edge and sweeps the filled region at a timed rate,
// presenting each read-back byte and its address to the display stage.
//   clock, resetn          : clock / asynchronous active-low reset
//   data_in, load_key      : byte to store, load request level
//   clear, scan_en         : synchronous buffer clear, sweep enable level
//   mem_addr/din/wren      : RAM control (owned entirely by this block)
//   mem_dout               : RAM read data, one cycle after the address
//   disp_addr/data/valid   : displayed byte, its address, real-read flag
//   count, full            : bytes stored (0..DEPTH), count == DEPTH
// Build option SEQ_WRAP_EN: when defined, a load into a full buffer
// overwrites the oldest byte (ring behaviour); otherwise it is ignored.
module ram_sequencer
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TICK_DIV = 50000000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_key,
    input  logic              clear,
    input  logic              scan_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [ADDR_W:0]   count,
    output logic              full
);

`ifdef SEQ_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam int              DEPTH_N  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH_N);
    localparam logic [ADDR_W:0] ONE_C    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    seq_state_t        state;
    logic              load_q;
    logic [DATA_W-1:0] din_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] scan_ptr;
    logic [ADDR_W:0]   count_q;

    logic              load_evt;
    logic              accept_load;
    logic              run;
    logic              tick;
    logic [ADDR_W:0]   scan_inc;

    assign load_evt = load_key && !load_q;
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;

    // Loads arriving during WRITE are dropped; loads into a full buffer
    // only proceed in ring mode.
    assign accept_load = load_evt && (state != WRITE) && (!full || WRAP_EN);

    // Gate the divider with everything that would pull the FSM out of
    // SCAN_WAIT this cycle so the counter restarts from zero on re-entry.
    assign run = (state == SCAN_WAIT) && scan_en && !clear && !accept_load;

    // Scan pointer advance, compared at count width so a full buffer
    // (count == DEPTH) wraps 31 -> 0 correctly.
    assign scan_inc = {1'b0, scan_ptr} + ONE_C;

    // RAM controls decode straight from registered state; outside WRITE
    // the read port simply follows the scan pointer.
    assign mem_wren = (state == WRITE);
    assign mem_addr = (state == WRITE) ? wr_ptr : scan_ptr;
    assign mem_din  = din_q;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .run    (run),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            load_q     <= 1'b0;
            din_q      <= '0;
            wr_ptr     <= '0;
            scan_ptr   <= '0;
            count_q    <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            load_q <= load_key;
            if (clear) begin
                state      <= IDLE;
                wr_ptr     <= '0;
                scan_ptr   <= '0;
                count_q    <= '0;
                disp_valid <= 1'b0;
            end else if (accept_load) begin
                din_q <= data_in;
                state <= WRITE;
            end else begin
                case (state)
                    IDLE: begin
                        if (scan_en && (count_q != '0)) begin
                            state <= SCAN_WAIT;
                        end
                    end
                    WRITE: begin
                        wr_ptr <= wr_ptr + ONE_A;
                        if (!full) begin
                            count_q <= count_q + ONE_C;
                        end
                        state <= IDLE;
                    end
                    SCAN_WAIT: begin
                        if (!scan_en) begin
                            state <= IDLE;
                        end else if (tick) begin
                            state <= SCAN_READ;
                        end
                    end
                    SCAN_READ: begin
                        state <= scan_en ? SCAN_CAPT : IDLE;
                    end
                    SCAN_CAPT: begin
                        if (!scan_en) begin
                            state <= IDLE;
                        end else begin
                            disp_data  <= mem_dout;
                            disp_addr  <= scan_ptr;
                            disp_valid <= 1'b1;
                            scan_ptr   <= (scan_inc == count_q) ? '0 : scan_inc[ADDR_W-1:0];
                            state      <= SCAN_WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ram_sequencer.md
Name: ram_sequencer

Overview:
Upstream address/data sequencer for the 32x8 synchronous single-port RAM (registered read, 1-cycle latency). Takes bytes from switches on a key strobe, writes them into consecutive RAM locations, and sweeps the filled region at a timed rate. Each read-back byte and its address go to the hex display stage. The block owns every RAM control input (address, write data, write enable) and consumes the RAM read data.

Parameters:
ADDR_W, 5, RAM address width; depth = 2**ADDR_W
DATA_W, 8, RAM data width
TICK_DIV, 50000000, clock cycles between scan steps (1 s at 50 MHz); minimum 4

Ports:
clock  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
data_in  input  DATA_W  byte to store
load_key  input  1  load request level (already synchronised); rising edge = one load
clear  input  1  synchronous: empty buffer, return to IDLE
scan_en  input  1  level: enable timed read-back sweep
mem_addr  output  ADDR_W  RAM address
mem_din  output  DATA_W  RAM write data
mem_wren  output  1  RAM write enable
mem_dout  input  DATA_W  RAM read data, valid the cycle after the address is presented
disp_addr  output  ADDR_W  address of the displayed byte
disp_data  output  DATA_W  displayed byte
disp_valid  output  1  high once disp_data holds a real read
count  output  ADDR_W+1  bytes stored, 0..2**ADDR_W
full  output  1  count == 2**ADDR_W

Behaviour:
- Reset (resetn low, asynchronous): all outputs 0; wr_ptr, scan pointer and tick counter 0; FSM to IDLE; load_key edge-detect register cleared to 0.
- Load event: load_key high this cycle and low last cycle (registered edge detect).
- FSM states: IDLE, WRITE, SCAN_WAIT, SCAN_READ, SCAN_CAPT.
- Priority each cycle: clear > load event > scan.
- clear: count, wr_ptr, scan pointer, tick counter := 0; disp_valid := 0; go to IDLE. disp_addr and disp_data hold their values.
- Load from IDLE or any SCAN state, not full: go to WRITE.
  - WRITE lasts exactly 1 cycle: mem_wren = 1, mem_addr = wr_ptr, mem_din = data_in (registered at the load event).
  - Next cycle: wr_ptr++ (wraps mod depth), count++, then return to IDLE.
- Load while full: ignored; state unchanged.
- Load arriving in WRITE: dropped. An edge cannot recur within 2 cycles in practice; no queueing.
- mem_wren is 0 in every state other than WRITE.
- IDLE with scan_en = 1 and count > 0: go to SCAN_WAIT.
- SCAN_WAIT: tick counter counts 0..TICK_DIV-1; at terminal count, reset the counter and go to SCAN_READ.
- SCAN_READ: mem_addr = scan pointer; go to SCAN_CAPT.
- SCAN_CAPT: latch disp_data = mem_dout, disp_addr = scan pointer, disp_valid = 1.
  - Scan pointer++; when it reaches count it wraps to 0.
  - Go to SCAN_WAIT.
- Scan step period: TICK_DIV + 2 cycles.
- scan_en falling in any SCAN state: go to IDLE, tick counter := 0; displayed values hold.
- Load interrupting a scan: after WRITE, re-enter IDLE. The scan resumes from the same pointer with a fresh tick count.
- mem_addr in IDLE/SCAN_WAIT: the scan pointer, so the RAM read port idles harmlessly.
- count == 0 with scan_en = 1: remain in IDLE; disp_valid stays 0.

Optional Feature:
Macro SEQ_WRAP_EN.
- Defined: buffer acts as a ring. When full, a load still writes at wr_ptr (overwriting the oldest byte) and wr_ptr advances. count stays at depth and full stays 1.
- Undefined: a load while full is ignored, as above.

Decomposition:
- Package ram_seq_pkg holds:
  - state enum (IDLE, WRITE, SCAN_WAIT, SCAN_READ, SCAN_CAPT)
  - ADDR_W/DATA_W defaults
  - DEPTH = 2**ADDR_W constant
- One sub-module: tick_divider (parameter TICK_DIV; inputs clock, resetn, run; output one-cycle tick at terminal count, zeroed when run is low).
- Edge detect and FSM stay inline.

Test Plan:
- Reset mid-WRITE (resetn low while mem_wren = 1) -> all outputs 0 immediately, count = 0, FSM IDLE.
- Three load edges with data_in = 8'hA1, 8'hB2, 8'hC3 -> one-cycle mem_wren pulses at addr 0, 1, 2 with those data; count = 3. Holding load_key high gives only one write.
- TICK_DIV = 4, scan_en = 1 after the above -> disp_addr/disp_data sequence 0/A1, 1/B2, 2/C3, 0/A1, with successive disp_data updates 6 cycles apart.
- 32 loads of value i (i = 0..31) -> full = 1, count = 32. A 33rd load with 8'hFF: no mem_wren without SEQ_WRAP_EN. With SEQ_WRAP_EN: write of FF at addr 0, count stays 32.
- Load edge during SCAN_WAIT -> WRITE at wr_ptr, scan resumes at the same pointer. clear during a scan -> count = 0, disp_valid = 0, IDLE.
